clk_gate_ctrl: RTL and testbench
================================

Name: clk_gate_ctrl

Overview:
Parametrised multi-channel clock-gating controller for the processor core. For each of NUM_CH channels it turns an activity request into a glitch-free gated clock. Channels stay on through a programmable idle hysteresis before gating off, and wake with one-cycle latency. It also provides test bypass, per-channel force-on, status outputs and a saturating counter of gated-off channel-cycles for power profiling.

Parameters:
NUM_CH, 4, number of independent gated-clock channels (1..32)
IDLE_CYCLES, 4, consecutive idle cycles tolerated before a channel gates off (0 = gate off on first idle cycle)
CNT_W, 32, width of off_cycles statistics counter
RESET_ON, 1, 1 = channels leave reset in ON state, 0 = leave reset in OFF state

Ports:
clk  input  1  free-running core clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
active  input  NUM_CH  per-channel activity request, sampled on rising clk
force_on  input  NUM_CH  per-channel override; treated as active=1
test_en  input  1  global bypass; all clk_gated follow clk, independent of FSM state
stat_clr  input  1  synchronous clear of off_cycles
clk_gated  output  NUM_CH  gated clocks
gate_status  output  NUM_CH  registered gate enable per channel (1 = clock running)
off_cycles  output  CNT_W  count of channel-cycles with gate_status=0, saturating

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is synchronous and active-low.
- Per-channel FSM states: OFF, ON, HOLD. Each channel has an idle counter of width clog2(IDLE_CYCLES+1), minimum 1 bit.
- Define req[i] = active[i] | force_on[i].
- OFF: if req, go to ON next edge; otherwise stay in OFF.
- ON: if req, stay in ON. If not req and IDLE_CYCLES=0, go to OFF. If not req and IDLE_CYCLES>0, go to HOLD with cnt=1.
- HOLD: if req, go to ON with cnt=0. Otherwise, if cnt==IDLE_CYCLES, go to OFF; else cnt+1.
- gate_status[i] is a register: 1 in ON and HOLD, 0 in OFF.
- Gating cell: a level-sensitive latch is transparent while clk=0 and captures gate_status[i] | test_en. Define clk_gated[i] = clk & latch_q[i]. The latch is the only path into the AND, so no glitches occur on either clk phase.
- Wake latency: req high at edge k sets gate_status=1 after edge k. The first gated high phase begins at edge k+1.
- Sleep: with IDLE_CYCLES=N>0 and req low from edge k onward, gate_status stays 1 through edge k+N and falls after edge k+N. The last gated pulse is at edge k+N.
- Reset (rst_n=0 at an edge): state = ON if RESET_ON else OFF; cnt=0; off_cycles=0.
- While rst_n=0, the latch input is forced to 1, so all clk_gated toggle. Downstream synchronous resets therefore take effect regardless of RESET_ON.
- Reset asserted mid-HOLD or mid-OFF overrides all other events in that cycle.
- off_cycles: each edge it adds the popcount of ~gate_status. The sum saturates at 2^CNT_W-1 and never wraps.
- stat_clr has priority over accumulation: the counter becomes 0 that edge, and that edge's count is discarded.
- Simultaneous events:
  - req and IDLE expiry in the same HOLD cycle: req wins, go to ON.
  - test_en does not alter FSM state or off_cycles. It only ungates the clocks.
- In SIMULATION builds the latch is behavioural. In synthesis builds it maps to an iCE40 negative-level latch-equivalent primitive (SB_DFFN with enable is not acceptable; clock edges must not be shifted).

Test Plan:
- Reset, RESET_ON=1, active=0, IDLE_CYCLES=4:
  - after rst_n rises, gate_status=4'b1111 for 5 edges (ON plus HOLD counts 1..4).
  - gate_status=0 after the 5th edge; clk_gated flat low afterward.
  - off_cycles increments by 4 per cycle.
- Wake: channel 2 in OFF, active[2] pulses one cycle at edge k:
  - gate_status[2]=1 after edge k.
  - clk_gated[2] produces a full high pulse starting at edge k+1, then 4 more pulses (5 total) before re-gating.
  - no partial or runt pulses, checked at the delta-cycle level.
- Hysteresis re-arm: active[0] low for 3 cycles, high 1 cycle, low again -> channel 0 never gates off; cnt returns to 0 on the active cycle.
- Overrides:
  - force_on[1]=1 with active=0 -> channel 1 stays ON indefinitely.
  - test_en=1 while all OFF -> all clk_gated equal clk, gate_status stays 0, off_cycles keeps incrementing.
- Saturation and clear, CNT_W=4, all channels OFF:
  - off_cycles reaches 15 after 4 edges and stays at 15.
  - stat_clr=1 -> 0 next edge; resumes 4, 8 afterward.
- Reset mid-HOLD, RESET_ON=0: channel in HOLD cnt=2, rst_n=0 one edge -> clk_gated toggles during reset; state OFF and off_cycles=0 after reset deasserts.

Source files
------------

// File: rtl/clk_gate_ctrl_if.sv
// Bundle of control inputs and gated-clock/status outputs for clk_gate_ctrl.
// The master side drives activity/override/bypass/clear, the slave side
// (the controller) returns the gated clocks, gate status and statistics.
interface clk_gate_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] force_on;
  logic              test_en;
  logic              stat_clr;
  logic [NUM_CH-1:0] clk_gated;
  logic [NUM_CH-1:0] gate_status;
  logic [CNT_W-1:0]  off_cycles;

  modport master (
    output active, force_on, test_en, stat_clr,
    input  clk_gated, gate_status, off_cycles
  );

  modport slave (
    input  active, force_on, test_en, stat_clr,
    output clk_gated, gate_status, off_cycles
  );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller. Each channel runs an OFF/ON/HOLD
// state machine with idle hysteresis; the registered gate enable drives a
// low-transparent latch whose output is ANDed with clk, giving glitch-free
// gated clocks. A saturating counter accumulates gated-off channel-cycles.
module clk_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_CYCLES = 4,
  parameter int CNT_W       = 32,
  parameter int RESET_ON    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  clk_gate_ctrl_if.slave cg
);

  localparam int IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
  localparam int PW = $clog2(NUM_CH + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [SW-1:0] SAT_MAX = (SW'(1) << CNT_W) - SW'(1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam state_t RST_STATE = (RESET_ON != 0) ? ST_ON : ST_OFF;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [IW-1:0]     cnt_q   [NUM_CH];
  logic [IW-1:0]     cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] gate_q;
  logic [NUM_CH-1:0] gate_d;
  logic [NUM_CH-1:0] req;
  logic [CNT_W-1:0]  off_q;
  logic [CNT_W-1:0]  off_d;
  logic [NUM_CH-1:0] latch_en;
  logic [NUM_CH-1:0] latch_q;

  // Number of set bits in a channel vector.
  function automatic logic [PW-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + PW'(v[i]);
    end
    return n;
  endfunction

  // Add without wrapping: clamp at the all-ones counter value.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PW-1:0]    b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SAT_MAX) begin
      s = SAT_MAX;
    end
    return s[CNT_W-1:0];
  endfunction

  assign req = cg.active | cg.force_on;

  // Per-channel next state, idle count and gate enable; statistics next value.
  always_comb begin
    gate_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (req[i]) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
          end
        end
        ST_ON: begin
          if (!req[i]) begin
            if (IDLE_CYCLES == 0) begin
              state_d[i] = ST_OFF;
              cnt_d[i]   = '0;
            end else begin
              state_d[i] = ST_HOLD;
              cnt_d[i]   = IW'(1);
            end
          end
        end
        ST_HOLD: begin
          // A request in the expiry cycle keeps the channel running.
          if (req[i]) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == IDLE_MAX) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + IW'(1);
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = '0;
        end
      endcase
      gate_d[i] = (state_d[i] != ST_OFF);
    end

    // Clear wins over accumulation; the current cycle's count is dropped.
    if (cg.stat_clr) begin
      off_d = '0;
    end else begin
      off_d = sat_add(off_q, popcount(~gate_q));
    end
  end

  // State, idle counters, gate enables and statistics; reset overrides all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= RST_STATE;
        cnt_q[i]   <= '0;
      end
      gate_q <= (RESET_ON != 0) ? '1 : '0;
      off_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      gate_q <= gate_d;
      off_q  <= off_d;
    end
  end

  // Bypass and reset both open every gate so downstream logic sees clocks.
  assign latch_en = gate_q | {NUM_CH{cg.test_en | ~rst_n}};

`ifdef SYNTHESIS
  // LUT-loop latch, transparent while clk is low; the D&Q consensus term
  // keeps the output steady when clk and D change together.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lat
    SB_LUT4 #(
      .LUT_INIT(16'hE2E2)
    ) u_lat (
      .O (latch_q[g]),
      .I0(latch_en[g]),
      .I1(clk),
      .I2(latch_q[g]),
      .I3(1'b0)
    );
  end
`else
  // Gate enable latch: follows latch_en only during the low clock phase.
  always_latch begin
    if (!clk) begin
      latch_q <= latch_en;
    end
  end
`endif

  assign cg.clk_gated   = {NUM_CH{clk}} & latch_q;
  assign cg.gate_status = gate_q;
  assign cg.off_cycles  = off_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: instance A (RESET_ON=1, 32-bit counter)
// and instance B (RESET_ON=0, 4-bit counter), both with IDLE_CYCLES=4.
module tb_clk_gate_ctrl;

  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  clk_gate_ctrl_if #(.NUM_CH(4), .CNT_W(32)) ifa ();
  clk_gate_ctrl_if #(.NUM_CH(4), .CNT_W(4))  ifb ();

  clk_gate_ctrl #(
    .NUM_CH(4), .IDLE_CYCLES(4), .CNT_W(32), .RESET_ON(1)
  ) dut_a (
    .clk  (clk),
    .rst_n(rst_a),
    .cg   (ifa)
  );

  clk_gate_ctrl #(
    .NUM_CH(4), .IDLE_CYCLES(4), .CNT_W(4), .RESET_ON(0)
  ) dut_b (
    .clk  (clk),
    .rst_n(rst_b),
    .cg   (ifb)
  );

  always #5 clk = ~clk;

  // Edge monitor: gated clocks may only rise while clk is high and fall
  // while clk is low; also counts rising pulses per channel.
  logic [3:0] cga_prev = 4'b0000;
  logic [3:0] cgb_prev = 4'b0000;
  int glitch_a = 0;
  int glitch_b = 0;
  int pulses_a2 = 0;

  always @(ifa.clk_gated) begin
    for (int i = 0; i < 4; i++) begin
      if (ifa.clk_gated[i] === 1'b1 && cga_prev[i] === 1'b0) begin
        if (clk !== 1'b1) glitch_a++;
        if (i == 2) pulses_a2++;
      end
      if (ifa.clk_gated[i] === 1'b0 && cga_prev[i] === 1'b1 && clk !== 1'b0)
        glitch_a++;
    end
    cga_prev = ifa.clk_gated;
  end

  always @(ifb.clk_gated) begin
    for (int i = 0; i < 4; i++) begin
      if (ifb.clk_gated[i] === 1'b1 && cgb_prev[i] === 1'b0 && clk !== 1'b1)
        glitch_b++;
      if (ifb.clk_gated[i] === 1'b0 && cgb_prev[i] === 1'b1 && clk !== 1'b0)
        glitch_b++;
    end
    cgb_prev = ifb.clk_gated;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_tests++;
    if (ifa.gate_status !== 4'hF) begin
      n_fail++; $display("FAIL reset_gate: got %b expected 1111", ifa.gate_status);
    end
    n_tests++;
    if (ifa.off_cycles !== 32'd0) begin
      n_fail++; $display("FAIL reset_off: got %0d expected 0", ifa.off_cycles);
    end
    n_tests++;
    if (ifa.clk_gated !== 4'hF) begin
      n_fail++; $display("FAIL reset_clk_high: got %b expected 1111", ifa.clk_gated);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (ifa.clk_gated !== 4'h0) begin
      n_fail++; $display("FAIL reset_clk_low: got %b expected 0000", ifa.clk_gated);
    end
    tick();
    rst_a = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_tests++;
      if (ifa.gate_status !== 4'hF) begin
        n_fail++; $display("FAIL hold_gate_e%0d: got %b expected 1111", e, ifa.gate_status);
      end
    end
    tick();
    n_tests++;
    if (ifa.gate_status !== 4'h0) begin
      n_fail++; $display("FAIL sleep_gate_e5: got %b expected 0000", ifa.gate_status);
    end
    n_tests++;
    if (ifa.clk_gated !== 4'hF) begin
      n_fail++; $display("FAIL last_pulse_e5: got %b expected 1111", ifa.clk_gated);
    end
    n_tests++;
    if (ifa.off_cycles !== 32'd0) begin
      n_fail++; $display("FAIL off_e5: got %0d expected 0", ifa.off_cycles);
    end
    tick();
    n_tests++;
    if (ifa.off_cycles !== 32'd4) begin
      n_fail++; $display("FAIL off_e6: got %0d expected 4", ifa.off_cycles);
    end
    n_tests++;
    if (ifa.clk_gated !== 4'h0) begin
      n_fail++; $display("FAIL gated_flat_e6: got %b expected 0000", ifa.clk_gated);
    end
    tick();
    n_tests++;
    if (ifa.off_cycles !== 32'd8) begin
      n_fail++; $display("FAIL off_e7: got %0d expected 8", ifa.off_cycles);
    end
  endtask

  task automatic test_wake();
    int p0;
    bit [8:1] exp_on;
    exp_on = 8'b0000_1111;
    ifa.active = 4'b0100;
    tick();
    ifa.active = 4'b0000;
    p0 = pulses_a2;
    n_tests++;
    if (ifa.gate_status !== 4'b0100) begin
      n_fail++; $display("FAIL wake_gate: got %b expected 0100", ifa.gate_status);
    end
    n_tests++;
    if (ifa.clk_gated !== 4'b0000) begin
      n_fail++; $display("FAIL wake_no_early_pulse: got %b expected 0000", ifa.clk_gated);
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 1) begin
        n_tests++;
        if (ifa.clk_gated !== 4'b0100) begin
          n_fail++; $display("FAIL wake_first_pulse: got %b expected 0100", ifa.clk_gated);
        end
      end
      n_tests++;
      if (ifa.gate_status !== {1'b0, exp_on[j], 2'b00}) begin
        n_fail++;
        $display("FAIL wake_gate_k+%0d: got %b expected %b", j, ifa.gate_status,
                 {1'b0, exp_on[j], 2'b00});
      end
    end
    n_tests++;
    if (pulses_a2 - p0 !== 5) begin
      n_fail++; $display("FAIL wake_pulse_count: got %0d expected 5", pulses_a2 - p0);
    end
  endtask

  task automatic test_rearm();
    bit [9:0] act_v;
    bit [9:0] exp_v;
    act_v = 10'b00_0001_0001;
    exp_v = 10'b01_1111_1111;
    for (int j = 0; j < 10; j++) begin
      ifa.active = {3'b000, act_v[j]};
      tick();
      n_tests++;
      if (ifa.gate_status !== {3'b000, exp_v[j]}) begin
        n_fail++;
        $display("FAIL rearm_step%0d: got %b expected %b", j, ifa.gate_status,
                 {3'b000, exp_v[j]});
      end
    end
    ifa.active = 4'b0000;
  endtask

  task automatic test_force();
    bit [4:0] rel_v;
    rel_v = 5'b01111;
    ifa.force_on = 4'b0010;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_tests++;
      if (ifa.gate_status !== 4'b0010) begin
        n_fail++; $display("FAIL force_on_c%0d: got %b expected 0010", j, ifa.gate_status);
      end
    end
    ifa.force_on = 4'b0000;
    for (int j = 0; j < 5; j++) begin
      tick();
      n_tests++;
      if (ifa.gate_status !== {2'b00, rel_v[j], 1'b0}) begin
        n_fail++;
        $display("FAIL force_release_c%0d: got %b expected %b", j, ifa.gate_status,
                 {2'b00, rel_v[j], 1'b0});
      end
    end
  endtask

  task automatic test_test_en();
    ifa.stat_clr = 1'b1;
    tick();
    n_tests++;
    if (ifa.off_cycles !== 32'd0) begin
      n_fail++; $display("FAIL clr_a: got %0d expected 0", ifa.off_cycles);
    end
    ifa.stat_clr = 1'b0;
    ifa.test_en  = 1'b1;
    tick();
    n_tests++;
    if (ifa.clk_gated !== 4'hF) begin
      n_fail++; $display("FAIL testen_high: got %b expected 1111", ifa.clk_gated);
    end
    n_tests++;
    if (ifa.gate_status !== 4'h0) begin
      n_fail++; $display("FAIL testen_gate: got %b expected 0000", ifa.gate_status);
    end
    n_tests++;
    if (ifa.off_cycles !== 32'd4) begin
      n_fail++; $display("FAIL testen_off1: got %0d expected 4", ifa.off_cycles);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (ifa.clk_gated !== 4'h0) begin
      n_fail++; $display("FAIL testen_low: got %b expected 0000", ifa.clk_gated);
    end
    tick();
    n_tests++;
    if (ifa.off_cycles !== 32'd8) begin
      n_fail++; $display("FAIL testen_off2: got %0d expected 8", ifa.off_cycles);
    end
    ifa.test_en = 1'b0;
    tick();
    n_tests++;
    if (ifa.clk_gated !== 4'h0) begin
      n_fail++; $display("FAIL testen_off_regate: got %b expected 0000", ifa.clk_gated);
    end
    n_tests++;
    if (ifa.off_cycles !== 32'd12) begin
      n_fail++; $display("FAIL testen_off3: got %0d expected 12", ifa.off_cycles);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_t [7];
    exp_t = '{4'd4, 4'd8, 4'd12, 4'd15, 4'd15, 4'd0, 4'd4};
    tick();
    n_tests++;
    if (ifb.gate_status !== 4'h0) begin
      n_fail++; $display("FAIL b_reset_gate: got %b expected 0000", ifb.gate_status);
    end
    n_tests++;
    if (ifb.clk_gated !== 4'hF) begin
      n_fail++; $display("FAIL b_reset_clk: got %b expected 1111", ifb.clk_gated);
    end
    n_tests++;
    if (ifb.off_cycles !== 4'd0) begin
      n_fail++; $display("FAIL b_reset_off: got %0d expected 0", ifb.off_cycles);
    end
    rst_b = 1'b1;
    for (int j = 0; j < 7; j++) begin
      ifb.stat_clr = (j == 5);
      tick();
      n_tests++;
      if (ifb.off_cycles !== exp_t[j]) begin
        n_fail++;
        $display("FAIL sat_step%0d: got %0d expected %0d", j, ifb.off_cycles, exp_t[j]);
      end
    end
    ifb.stat_clr = 1'b0;
    tick();
    n_tests++;
    if (ifb.off_cycles !== 4'd8) begin
      n_fail++; $display("FAIL sat_resume: got %0d expected 8", ifb.off_cycles);
    end
  endtask

  task automatic test_reset_mid_hold();
    ifb.active = 4'b1000;
    tick();
    ifb.active = 4'b0000;
    tick();
    tick();
    n_tests++;
    if (ifb.gate_status !== 4'b1000) begin
      n_fail++; $display("FAIL midhold_pre: got %b expected 1000", ifb.gate_status);
    end
    rst_b = 1'b0;
    tick();
    n_tests++;
    if (ifb.clk_gated !== 4'hF) begin
      n_fail++; $display("FAIL midhold_rst_clk: got %b expected 1111", ifb.clk_gated);
    end
    n_tests++;
    if (ifb.gate_status !== 4'h0) begin
      n_fail++; $display("FAIL midhold_rst_gate: got %b expected 0000", ifb.gate_status);
    end
    n_tests++;
    if (ifb.off_cycles !== 4'd0) begin
      n_fail++; $display("FAIL midhold_rst_off: got %0d expected 0", ifb.off_cycles);
    end
    rst_b = 1'b1;
    tick();
    n_tests++;
    if (ifb.gate_status !== 4'h0) begin
      n_fail++; $display("FAIL midhold_post_gate: got %b expected 0000", ifb.gate_status);
    end
    n_tests++;
    if (ifb.off_cycles !== 4'd4) begin
      n_fail++; $display("FAIL midhold_post_off: got %0d expected 4", ifb.off_cycles);
    end
    n_tests++;
    if (ifb.clk_gated !== 4'h0) begin
      n_fail++; $display("FAIL midhold_post_clk: got %b expected 0000", ifb.clk_gated);
    end
  endtask

  task automatic test_glitch();
    n_tests++;
    if (glitch_a !== 0) begin
      n_fail++; $display("FAIL glitch_a: got %0d expected 0", glitch_a);
    end
    n_tests++;
    if (glitch_b !== 0) begin
      n_fail++; $display("FAIL glitch_b: got %0d expected 0", glitch_b);
    end
  endtask

  initial begin
    ifa.active = '0; ifa.force_on = '0; ifa.test_en = 1'b0; ifa.stat_clr = 1'b0;
    ifb.active = '0; ifb.force_on = '0; ifb.test_en = 1'b0; ifb.stat_clr = 1'b0;
    test_reset();
    test_wake();
    test_rearm();
    test_force();
    test_test_en();
    test_saturation();
    test_reset_mid_hold();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
